// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - single-outstanding load/store unit between a pipeline port and a synchronous data memory
module load_store_unit #(
   parameter int MEM_DEPTH = 16,
   parameter int ADDR_W    = 14
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [31:0]       req_addr,
   input  logic [31:0]       req_wdata,
   output logic              req_ready,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [31:0]       resp_rdata,
   output logic              resp_error,
   output logic              mem_enable,
   output logic              mem_write_enable,
   output logic              mem_read_enable,
   output logic [ADDR_W-1:0] mem_address,
   output logic [31:0]       mem_input_data,
   input  logic [31:0]       mem_output_data
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   // One extra bit so a depth of exactly 2**ADDR_W words still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_LIMIT = (ADDR_W + 1)'(MEM_DEPTH);

   state_t            state;
   state_t            state_next;
   logic              write_q;
   logic              error_q;
   logic [ADDR_W-1:0] addr_q;
   logic [31:0]       wdata_q;
   logic [31:0]       rdata_q;

   logic [ADDR_W-1:0] word_addr;
   logic              misaligned;
   logic              high_bits;
   logic              out_of_depth;
   logic              req_error;
   logic              accept;

   assign word_addr    = req_addr[ADDR_W+1:2];
   assign misaligned   = |req_addr[1:0];
   assign high_bits    = |req_addr[31:ADDR_W+2];
   assign out_of_depth = ({1'b0, word_addr} >= DEPTH_LIMIT);
   assign req_error    = misaligned | high_bits | out_of_depth;
   assign accept       = req_valid && (state == IDLE);

   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next       = state;
      req_ready        = 1'b0;
      resp_valid       = 1'b0;
      mem_enable       = 1'b0;
      mem_read_enable  = 1'b0;
      mem_write_enable = 1'b0;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (req_valid) begin
               state_next = req_error ? RESP : ISSUE;
            end
         end
         ISSUE: begin
            mem_enable       = 1'b1;
            mem_read_enable  = ~write_q;
            mem_write_enable = write_q;
            state_next       = write_q ? RESP : WAIT;
         end
         WAIT: begin
            state_next = RESP;
         end
         RESP: begin
            resp_valid = 1'b1;
            if (resp_ready) begin
               state_next = IDLE;
            end
         end
         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // Request fields are captured once at acceptance so memory outputs stay stable until the response.
   always_ff @(posedge clk) begin
      if (!rst) begin
         write_q <= 1'b0;
         error_q <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         rdata_q <= '0;
      end else if (accept) begin
         write_q <= req_write;
         error_q <= req_error;
         addr_q  <= word_addr;
         wdata_q <= req_wdata;
         rdata_q <= '0;
      end else if (state == WAIT) begin
         rdata_q <= mem_output_data;
      end
   end

   assign resp_rdata     = rdata_q;
   assign resp_error     = error_q;
   assign mem_address    = addr_q;
   assign mem_input_data = wdata_q;

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter MEM_DEPTH, default 16, SHALL give the number of 32-bit words in the attached data memory.
REQ-002 Parameter ADDR_W, default 14, SHALL give the width of the data-memory word address.
REQ-003 clk  input  1  SHALL be the single clock; all state changes on its rising edge.
REQ-004 rst  input  1  SHALL be the reset: synchronous, active-low.
REQ-005 req_valid  input  1  SHALL mark a pipeline memory request.
REQ-006 req_write  input  1  SHALL select store (1) or load (0).
REQ-007 req_addr  input  32  SHALL be the request byte address.
REQ-008 req_wdata  input  32  SHALL be the store data.
REQ-009 req_ready  output  1  SHALL indicate a request can be accepted.
REQ-010 resp_valid  output  1  SHALL mark a completed request.
REQ-011 resp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-012 resp_rdata  output  32  SHALL carry load data; 0 for stores and errors.
REQ-013 resp_error  output  1  SHALL flag a misaligned or out-of-range request.
REQ-014 mem_enable, mem_write_enable, mem_read_enable  output  1 each  SHALL drive the data memory strobes.
REQ-015 mem_address  output  ADDR_W  SHALL be the data-memory word address.
REQ-016 mem_input_data  output  32  SHALL be the data-memory write data.
REQ-017 mem_output_data  input  32  SHALL be the data-memory read data, valid one clock after a read strobe edge.

Function
REQ-018 Request SHALL be accepted on a rising edge where req_valid=1 and req_ready=1; req_addr, req_write and req_wdata SHALL be registered at acceptance.
REQ-019 Word address SHALL be req_addr[ADDR_W+1:2].
REQ-020 Request SHALL be an error if req_addr[1:0]!=0, or req_addr[31:ADDR_W+2]!=0, or word address >= MEM_DEPTH.
REQ-021 FSM states SHALL be IDLE, ISSUE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-022 IDLE: on acceptance -> RESP if error, else -> ISSUE.
REQ-023 ISSUE (exactly one cycle): mem_enable=1; mem_read_enable=~write; mem_write_enable=write; -> WAIT for loads, -> RESP for stores.
REQ-024 WAIT (one cycle): resp_rdata SHALL capture mem_output_data at the closing edge; -> RESP.
REQ-025 RESP: resp_valid=1; resp_rdata and resp_error SHALL hold stable until an edge with resp_ready=1, then -> IDLE.
REQ-026 Outside ISSUE all three memory strobes SHALL be 0; mem_read_enable and mem_write_enable SHALL never both be 1.
REQ-027 mem_address and mem_input_data SHALL be driven from the registered request and remain stable through ISSUE and WAIT.
REQ-028 Error requests SHALL never assert any memory strobe; resp_rdata=0, resp_error=1.
REQ-029 Latency from acceptance edge to first resp_valid=1 cycle: error 1, store 2, load 3 cycles.
REQ-030 At most one request SHALL be outstanding; a new request SHALL not be accepted in the cycle the response is consumed.

Reset
REQ-031 With rst=0 at a rising edge the FSM SHALL enter IDLE from any state, dropping any pending request.
REQ-032 Reset values: req_ready=1 in the cycle after reset released state, resp_valid=0, resp_rdata=0, resp_error=0, all memory strobes 0, mem_address=0, mem_input_data=0.
REQ-033 Reset asserted during ISSUE SHALL deassert all strobes from the following cycle; no further memory write SHALL occur.

Verification
REQ-034 Store req_addr=0x8, wdata=0xDEADBEEF -> one ISSUE cycle with mem_address=2, write strobe; resp_valid 2 cycles after acceptance, resp_error=0, resp_rdata=0.
REQ-035 Load req_addr=0x8 after that store -> mem_read_enable one cycle at address 2; resp_valid 3 cycles after acceptance with resp_rdata=0xDEADBEEF.
REQ-036 Load req_addr=0x6 (misaligned) and req_addr=0x40 (word 16, MEM_DEPTH=16) -> no strobes; resp_valid 1 cycle after acceptance, resp_error=1, resp_rdata=0.
REQ-037 Load completes with resp_ready=0 for 4 cycles -> resp_valid and resp_rdata held stable; req_ready=0 throughout; IDLE after the resp_ready=1 edge.
REQ-038 rst=0 asserted in the ISSUE cycle of a store to 0x4 -> all outputs at reset values next cycle; back-to-back requests afterward accepted normally.
